// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, funct codes and state types
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        CTRL_ADD,
        CTRL_SUB,
        CTRL_AND,
        CTRL_OR,
        CTRL_XOR,
        CTRL_NOR,
        CTRL_SLT,
        CTRL_SLTU,
        CTRL_MFHI,
        CTRL_MFLO,
        CTRL_MULDIV,
        CTRL_NONE
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider owning HI/LO
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    // op[0] set means the unsigned variant; op[1] set means divide
    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign sgn   = ~op[0];
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign add_sum = {1'b0, acc_hi} + {1'b0, opnd};
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd};

    // One iteration: mul shifts the partial product right, div shifts the remainder left
    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, acc_hi[WIDTH-1:1]};
            step_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_res ? -prod : prod;

    // Sign correction and divide-by-zero override applied to the final step result
    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fin_hi = a_lat;
                fin_lo = '1;
            end else begin
                fin_hi = neg_rem ? -step_hi : step_hi;
                fin_lo = neg_res ? -step_lo : step_lo;
            end
        end
    end

    // Engine FSM; HI/LO and done are written on the last RUN step so FIN shows them
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_lat    <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_res  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= sgn & a[WIDTH-1];
                        div_zero <= (b == '0);
                        a_lat    <= a;
                        opnd     <= b_mag;
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - execute-stage ALU with optional mult/div engine (ALU_MULDIV_EN)
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       Alu_op,
    input  logic [5:0]       funct,
    input  logic             start,
    output logic             zero,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             lt_u;

    // Decode main-control class and R-type funct into a single operation code
    always_comb begin
        ctrl = CTRL_ADD;
        case (Alu_op)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: ctrl = CTRL_ADD;
                    F_SUB, F_SUBU: ctrl = CTRL_SUB;
                    F_AND:         ctrl = CTRL_AND;
                    F_OR:          ctrl = CTRL_OR;
                    F_XOR:         ctrl = CTRL_XOR;
                    F_NOR:         ctrl = CTRL_NOR;
                    F_SLT:         ctrl = CTRL_SLT;
                    F_SLTU:        ctrl = CTRL_SLTU;
`ifdef ALU_MULDIV_EN
                    F_MFHI:        ctrl = CTRL_MFHI;
                    F_MFLO:        ctrl = CTRL_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = CTRL_MULDIV;
`endif
                    default:       ctrl = CTRL_NONE;
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

`ifdef ALU_MULDIV_EN
    logic md_start;

    assign md_start = start & (ctrl == CTRL_MULDIV);

    muldiv_unit #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (funct[1:0]),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst, start};
    assign busy = 1'b0;
    assign done = 1'b0;
    assign hi   = '0;
    assign lo   = '0;
`endif

    // Single-cycle result mux; mult/div launches and unknown functs read as zero
    always_comb begin
        result = '0;
        case (ctrl)
            CTRL_ADD:  result = sum;
            CTRL_SUB:  result = diff;
            CTRL_AND:  result = a & b;
            CTRL_OR:   result = a | b;
            CTRL_XOR:  result = a ^ b;
            CTRL_NOR:  result = ~(a | b);
            CTRL_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            CTRL_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            CTRL_MFHI: result = hi;
            CTRL_MFLO: result = lo;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv
module tb_alu_muldiv;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic        start = 1'b0;
    logic        zero;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } comb_vec_t;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .Alu_op (alu_op),
        .funct  (funct),
        .start  (start),
        .zero   (zero),
        .result (result),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0] res;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        res = '0;
        case (f)
            F_MULT:  res = sx * sy;
            F_MULTU: res = {32'd0, x} * {32'd0, y};
            F_DIV: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; alu_op = 2'b00; funct = '0; a = '0; b = '0;
        tick;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_comb;
        comb_vec_t tbl[$];
        tbl.push_back('{2'b10, 6'h20, 32'd5,          32'd7,          32'd12});
        tbl.push_back('{2'b01, 6'h00, 32'd9,          32'd9,          32'd0});
        tbl.push_back('{2'b10, 6'h21, 32'hFFFF_FFFF,  32'd1,          32'd0});
        tbl.push_back('{2'b10, 6'h22, 32'd3,          32'd5,          32'hFFFF_FFFE});
        tbl.push_back('{2'b10, 6'h23, 32'd10,         32'd10,         32'd0});
        tbl.push_back('{2'b10, 6'h24, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000});
        tbl.push_back('{2'b10, 6'h25, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF});
        tbl.push_back('{2'b10, 6'h26, 32'h0000_FFFF,  32'h0000_0F0F,  32'h0000_F0F0});
        tbl.push_back('{2'b10, 6'h27, 32'd0,          32'd0,          32'hFFFF_FFFF});
        tbl.push_back('{2'b10, 6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1});
        tbl.push_back('{2'b10, 6'h2B, 32'hFFFF_FFFF,  32'd1,          32'd0});
        tbl.push_back('{2'b10, 6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0});
        tbl.push_back('{2'b10, 6'h2B, 32'd1,          32'hFFFF_FFFF,  32'd1});
        tbl.push_back('{2'b10, 6'h3F, 32'd5,          32'd5,          32'd0});
        tbl.push_back('{2'b10, 6'h18, 32'd5,          32'd7,          32'd0});
        tbl.push_back('{2'b00, 6'h2A, 32'd5,          32'd7,          32'd12});
        tbl.push_back('{2'b11, 6'h00, 32'd2,          32'd3,          32'd5});
        tbl.push_back('{2'b01, 6'h00, 32'd3,          32'd5,          32'hFFFF_FFFE});
        start = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            tick;
            alu_op = tbl[i].op; funct = tbl[i].f; a = tbl[i].x; b = tbl[i].y;
            #2;
            checks++;
            if (result !== tbl[i].exp) begin
                errors++;
                $display("FAIL comb_result[%0d]: got %h expected %h", i, result, tbl[i].exp);
            end
            checks++;
            if (zero !== (tbl[i].exp == 32'd0)) begin
                errors++;
                $display("FAIL comb_zero[%0d]: got %b expected %b", i, zero, (tbl[i].exp == 32'd0));
            end
        end
    endtask

`ifdef ALU_MULDIV_EN
    // Launches one op and walks it to its done cycle; returns inside that cycle
    task automatic run_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit inject);
        logic [63:0] exp;
        exp_q.push_back(md_model(f, x, y));
        alu_op = 2'b10; funct = f; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0; a = $urandom; b = $urandom;
        for (int k = 1; k <= 32; k++) begin
            if (k == 3) funct = F_MFLO;
            if (k == 4) funct = F_MFHI;
            if (inject && k == 5) begin start = 1'b1; funct = F_MULT; a = 32'd1; b = 32'd1; end
            if (inject && k == 6) start = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_window: cycle %0d got %b expected 1", k, busy); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL early_done: cycle %0d got %b expected 0", k, done); end
            if (k == 3) begin
                checks++;
                if (result !== model_lo) begin errors++; $display("FAIL mflo_busy: got %h expected %h", result, model_lo); end
            end
            if (k == 4) begin
                checks++;
                if (result !== model_hi) begin errors++; $display("FAIL mfhi_busy: got %h expected %h", result, model_hi); end
            end
            tick;
        end
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_cycle: got %b expected 1", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            model_hi = exp[63:32];
            model_lo = exp[31:0];
            checks++;
            if (hi !== model_hi) begin errors++; $display("FAIL md_hi f=%h a=%h b=%h: got %h expected %h", f, x, y, hi, model_hi); end
            checks++;
            if (lo !== model_lo) begin errors++; $display("FAIL md_lo f=%h a=%h b=%h: got %h expected %h", f, x, y, lo, model_lo); end
        end
        funct = F_MFHI;
        #1;
        checks++;
        if (result !== model_hi) begin errors++; $display("FAIL mfhi_after: got %h expected %h", result, model_hi); end
        funct = F_MFLO;
        #1;
        checks++;
        if (result !== model_lo) begin errors++; $display("FAIL mflo_after: got %h expected %h", result, model_lo); end
    endtask

    task automatic check_idle_after;
        start = 1'b0;
        tick;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy); end
    endtask

    task automatic test_mult;
        run_md(F_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check_idle_after;
        run_md(F_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check_idle_after;
        run_md(F_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        check_idle_after;
        for (int i = 0; i < 3; i++) begin
            run_md(F_MULT,  $urandom, $urandom, 1'b0);
            check_idle_after;
            run_md(F_MULTU, $urandom, $urandom, 1'b0);
            check_idle_after;
        end
    endtask

    task automatic test_div;
        run_md(F_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
        check_idle_after;
        run_md(F_DIVU, 32'd7, 32'd0, 1'b0);
        check_idle_after;
        run_md(F_DIV,  32'hFFFF_FFFB, 32'd0, 1'b0);
        check_idle_after;
        run_md(F_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0);
        check_idle_after;
        run_md(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_idle_after;
        run_md(F_DIVU, 32'd100, 32'd7, 1'b0);
        check_idle_after;
        for (int i = 0; i < 3; i++) begin
            run_md(F_DIV,  $urandom, {16'd0, 16'($urandom_range(1, 65535))}, 1'b0);
            check_idle_after;
            run_md(F_DIVU, $urandom, $urandom, 1'b0);
            check_idle_after;
        end
    endtask

    task automatic test_busy;
        run_md(F_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check_idle_after;
        tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_ran: got busy %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        run_md(F_MULTU, 32'd12345, 32'd678, 1'b0);
        run_md(F_DIV,   32'hFFFF_FF00, 32'd7, 1'b0);
        run_md(F_DIVU,  32'hDEAD_BEEF, 32'd16, 1'b0);
        check_idle_after;
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        alu_op = 2'b10; funct = F_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        checks++;
        if (hi !== 32'd0) begin errors++; $display("FAIL reset_mid_hi: got %h expected 0", hi); end
        checks++;
        if (lo !== 32'd0) begin errors++; $display("FAIL reset_mid_lo: got %h expected 0", lo); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
            tick;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL reset_mid_activity: got done/busy 1 expected none"); end
    endtask
`else
    task automatic test_no_engine;
        bit active;
        alu_op = 2'b10; funct = F_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        active = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) active = 1'b1;
            tick;
        end
        checks++;
        if (active) begin errors++; $display("FAIL no_engine_activity: got busy/done 1 expected 0"); end
        checks++;
        if (hi !== 32'd0) begin errors++; $display("FAIL no_engine_hi: got %h expected 0", hi); end
        checks++;
        if (lo !== 32'd0) begin errors++; $display("FAIL no_engine_lo: got %h expected 0", lo); end
        funct = F_MFHI;
        #1;
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL no_engine_mfhi: got %h expected 0", result); end
        funct = F_MFLO;
        #1;
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL no_engine_mflo: got %h expected 0", result); end
        funct = F_DIVU;
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL no_engine_divu: got %h/%b expected 0/1", result, zero); end
    endtask
`endif

    initial begin
        test_reset;
        test_comb;
`ifdef ALU_MULDIV_EN
        test_mult;
        test_div;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
`else
        test_no_engine;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
